// File: rtl/instruction_loader_pkg.sv
// ---------------------------------------------------------------------------
// instruction_loader_pkg
//   Shared processor constants used by the instruction loader:
//   - state_e  : loader FSM state encodings
//   - NOP_INSN : RV32I canonical NOP (addi x0, x0, 0)
//   - nop_byte : little-endian byte lane of NOP_INSN, selected by a 2-bit index
// ---------------------------------------------------------------------------
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Byte lane idx of the NOP word, lane 0 being the least significant byte.
  function automatic logic [7:0] nop_byte(input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = NOP_INSN >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//   Streams a program, one byte per handshake, into a byte-wide instruction
//   memory starting at BASE_ADDR. A short program is padded with NOPs up to
//   MEM_BYTES; an overlong one is truncated and flagged. The processor is held
//   while the memory is being rewritten.
//
// Parameters
//   MEM_BYTES : instruction memory size in bytes (multiple of 4, >= 4)
//   BASE_ADDR : byte address of the first loaded byte (multiple of 4)
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset
//   start     in   single-cycle load request (honoured in IDLE/DONE only)
//   in_valid  in   in_data holds a program byte
//   in_data   in   program byte, ascending address order
//   in_last   in   marks the final program byte
//   in_ready  out  loader accepts a byte this cycle
//   mem_we    out  byte write strobe (one cycle after the accepting edge)
//   mem_addr  out  byte write address
//   mem_wdata out  byte write data
//   cpu_hold  out  hold the processor fetch while memory is rewritten
//   done      out  load complete, held until next start/reset
//   error     out  misaligned or overflowed load, held until next start/reset
// ---------------------------------------------------------------------------
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = $clog2(MEM_BYTES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_BYTES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             mem_we_q, mem_we_d;
  logic [63:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             handshake;

  // cnt may sit at MEM_BYTES in LOAD for one cycle after an overflow, so
  // in_ready must also check the count, not just the state.
  assign in_ready  = (state_q == LOAD) && (cnt_q < CNT_MAX);
  assign handshake = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end

      LOAD: begin
        if (handshake) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + 64'(cnt_q);
          mem_wdata_d = in_data;
          cnt_d       = cnt_inc;
          if (in_last) begin
            if (cnt_inc == CNT_MAX) begin
              state_d = DONE;
            end else begin
              // A program that does not end on an instruction boundary
              // still gets padded, but is reported as misaligned.
              state_d = FILL;
              error_d = (cnt_inc[1:0] != 2'b00);
            end
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = DONE;
          error_d = 1'b1;
        end
      end

      FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR + 64'(cnt_q);
        mem_wdata_d = nop_byte(cnt_q[1:0]);
        cnt_d       = cnt_inc;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered so they line up with the state they describe;
    // cpu_hold also covers the cycle carrying the last write pulse.
    done_d     = (state_d == DONE);
    cpu_hold_d = (state_d == LOAD) || (state_d == FILL) || mem_we_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      cpu_hold_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      done_q      <= done_d;
      cpu_hold_q  <= cpu_hold_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
